// File: rtl/arm_pc_pkg.sv
// Shared definitions for the LEGv8 fetch stage: FSM state encoding,
// instruction size and opcode field position.
package arm_pc_pkg;

  typedef enum logic [1:0] {
    ST_RST   = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2
  } fetch_state_e;

  localparam int INST_BYTES = 4;
  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 21;

endpackage

// File: rtl/next_pc_calc.sv
// Next program counter: sequential step or branch target, both modulo 2^XLEN.
// The word offset is scaled to bytes by a left shift that drops its top two bits.
module next_pc_calc
  import arm_pc_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] currentpc,
  input  logic [XLEN-1:0] signext_imm,
  input  logic            branch,
  input  logic            uncond_branch,
  input  logic            zero,
  output logic [XLEN-1:0] next_pc
);

  logic            taken;
  logic [XLEN-1:0] byte_offset;

  // Pick branch target or fall-through and add to the current PC.
  always_comb begin
    taken       = uncond_branch | (branch & zero);
    byte_offset = signext_imm << 2;
    if (taken) begin
      next_pc = currentpc + byte_offset;
    end else begin
      next_pc = currentpc + XLEN'(INST_BYTES);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds the PC, issues one request at a time to
// instruction memory over req/ack, and presents the fetched word to execute.
// Optional feature macro: FETCH_PERF_CNT_EN adds retired_cnt / stall_cnt.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_RST   | reset held; PC tracks startpc, nothing requested or valid
// ST_FETCH | request outstanding at currentpc, waiting for imem_ack
// ST_HOLD  | instruction valid for execute, waiting for retire
module fetch_unit
  import arm_pc_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            CLK,
  input  logic            reset,
  input  logic [XLEN-1:0] startpc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic            inst_valid,
  output logic [31:0]     instruction,
  output logic [10:0]     opcode,
  output logic [XLEN-1:0] currentpc,
  input  logic            retire,
  input  logic            branch,
  input  logic            uncond_branch,
  input  logic            zero,
  input  logic [XLEN-1:0] signext_imm
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]     retired_cnt,
  output logic [31:0]     stall_cnt
`endif
);

  fetch_state_e    state;
  logic [XLEN-1:0] next_pc;

  next_pc_calc #(.XLEN(XLEN)) u_next_pc_calc (
    .currentpc     (currentpc),
    .signext_imm   (signext_imm),
    .branch        (branch),
    .uncond_branch (uncond_branch),
    .zero          (zero),
    .next_pc       (next_pc)
  );

  assign imem_addr = currentpc;
  assign opcode    = instruction[OPCODE_MSB:OPCODE_LSB];

  // Fetch sequencing; outputs are registered alongside the state so they
  // change exactly one cycle after the ack / retire that causes them.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state       <= ST_RST;
      currentpc   <= startpc;
      imem_req    <= 1'b0;
      inst_valid  <= 1'b0;
      instruction <= 32'h0;
    end else begin
      case (state)
        ST_RST: begin
          state    <= ST_FETCH;
          imem_req <= 1'b1;
        end
        ST_FETCH: begin
          if (imem_ack) begin
            instruction <= imem_rdata;
            imem_req    <= 1'b0;
            inst_valid  <= 1'b1;
            state       <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (retire) begin
            currentpc  <= next_pc;
            inst_valid <= 1'b0;
            imem_req   <= 1'b1;
            state      <= ST_FETCH;
          end
        end
        default: begin
          state      <= ST_RST;
          imem_req   <= 1'b0;
          inst_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  // Performance counters: accepted retires and ack-less fetch cycles.
  always_ff @(posedge CLK) begin
    if (reset) begin
      retired_cnt <= 32'h0;
      stall_cnt   <= 32'h0;
    end else begin
      if (state == ST_HOLD && retire) begin
        retired_cnt <= retired_cnt + 32'h1;
      end
      if (state == ST_FETCH && !imem_ack) begin
        stall_cnt <= stall_cnt + 32'h1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized
// fetch/retire transactions against a transaction-level PC model.
module tb_fetch_unit;

  localparam int XLEN = 64;

  logic            CLK = 1'b0;
  logic            reset;
  logic [XLEN-1:0] startpc;
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ack;
  logic [31:0]     imem_rdata;
  logic            inst_valid;
  logic [31:0]     instruction;
  logic [10:0]     opcode;
  logic [XLEN-1:0] currentpc;
  logic            retire;
  logic            branch;
  logic            uncond_branch;
  logic            zero;
  logic [XLEN-1:0] signext_imm;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0]     retired_cnt;
  logic [31:0]     stall_cnt;
`endif

  fetch_unit #(.XLEN(XLEN)) dut (
    .CLK           (CLK),
    .reset         (reset),
    .startpc       (startpc),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .inst_valid    (inst_valid),
    .instruction   (instruction),
    .opcode        (opcode),
    .currentpc     (currentpc),
    .retire        (retire),
    .branch        (branch),
    .uncond_branch (uncond_branch),
    .zero          (zero),
    .signext_imm   (signext_imm)
`ifdef FETCH_PERF_CNT_EN
    ,
    .retired_cnt   (retired_cnt),
    .stall_cnt     (stall_cnt)
`endif
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  // Transaction-level reference state.
  logic [XLEN-1:0] model_pc;
  logic [31:0]     model_inst;
  int              model_retired;
  int              model_stalls;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [10:0] opcode_of(input logic [31:0] w);
    logic [31:0] s;
    s = w >> 21;
    return s[10:0];
  endfunction

  task automatic do_reset(input logic [XLEN-1:0] pc, input int cycles);
    startpc = pc;
    reset   = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      tick();
      chk("rst_req", {63'd0, imem_req}, 64'd0);
      chk("rst_valid", {63'd0, inst_valid}, 64'd0);
    end
    chk("rst_pc", currentpc, pc);
    chk("rst_inst", {32'd0, instruction}, 64'd0);
    chk("rst_opcode", {53'd0, opcode}, 64'd0);
    reset         = 1'b0;
    model_pc      = pc;
    model_inst    = 32'h0;
    model_retired = 0;
    model_stalls  = 0;
    tick();
    chk("first_req", {63'd0, imem_req}, 64'd1);
    chk("first_addr", imem_addr, pc);
  endtask

  // Already in a FETCH cycle on entry; leaves the DUT in HOLD.
  task automatic fetch_txn(input int waits, input logic [31:0] data);
    for (int i = 0; i < waits; i++) begin
      chk("wait_req", {63'd0, imem_req}, 64'd1);
      chk("wait_addr", imem_addr, model_pc);
      chk("wait_valid", {63'd0, inst_valid}, 64'd0);
      tick();
    end
    model_stalls += waits;
    imem_ack   = 1'b1;
    imem_rdata = data;
    tick();
    imem_ack   = 1'b0;
    imem_rdata = $urandom;
    model_inst = data;
    chk("ack_valid", {63'd0, inst_valid}, 64'd1);
    chk("ack_req", {63'd0, imem_req}, 64'd0);
    chk("ack_inst", {32'd0, instruction}, {32'd0, data});
    chk("ack_opcode", {53'd0, opcode}, {53'd0, opcode_of(data)});
    chk("ack_pc", currentpc, model_pc);
  endtask

  // In HOLD on entry; leaves the DUT in the first FETCH cycle of the next PC.
  task automatic retire_txn(input int hold, input logic br, input logic ub,
                            input logic z, input logic [XLEN-1:0] imm);
    for (int i = 0; i < hold; i++) begin
      imem_ack   = 1'b1;
      imem_rdata = ~model_inst;
      tick();
      chk("hold_valid", {63'd0, inst_valid}, 64'd1);
      chk("hold_inst", {32'd0, instruction}, {32'd0, model_inst});
      chk("hold_req", {63'd0, imem_req}, 64'd0);
    end
    imem_ack      = 1'b0;
    retire        = 1'b1;
    branch        = br;
    uncond_branch = ub;
    zero          = z;
    signext_imm   = imm;
    tick();
    retire        = 1'b0;
    branch        = $urandom_range(0, 1);
    uncond_branch = 1'b0;
    zero          = $urandom_range(0, 1);
    signext_imm   = {$urandom, $urandom};
    if (ub || (br && z)) model_pc = model_pc + imm * 4;
    else                 model_pc = model_pc + 4;
    model_retired++;
    chk("ret_addr", imem_addr, model_pc);
    chk("ret_pc", currentpc, model_pc);
    chk("ret_req", {63'd0, imem_req}, 64'd1);
    chk("ret_valid", {63'd0, inst_valid}, 64'd0);
  endtask

  task automatic chk_counters();
`ifdef FETCH_PERF_CNT_EN
    chk("retired_cnt", {32'd0, retired_cnt}, 64'(model_retired));
    chk("stall_cnt", {32'd0, stall_cnt}, 64'(model_stalls));
`endif
  endtask

  initial begin
    reset         = 1'b1;
    startpc       = 64'h0;
    imem_ack      = 1'b0;
    imem_rdata    = 32'h0;
    retire        = 1'b0;
    branch        = 1'b0;
    uncond_branch = 1'b0;
    zero          = 1'b0;
    signext_imm   = 64'h0;

    // Basic flow from 0x100 with the worked opcode example.
    do_reset(64'h100, 3);
    fetch_txn(3, 32'h8B02_0020);
    chk("opcode_458", {53'd0, opcode}, 64'h458);
    retire_txn(2, 1'b0, 1'b0, 1'b0, 64'd0);
    chk("seq_104", imem_addr, 64'h104);
    fetch_txn(0, 32'hB400_0040);
    retire_txn(0, 1'b1, 1'b0, 1'b1, -64'sd2);
    chk("cbz_taken", imem_addr, 64'hFC);
    fetch_txn(1, 32'hB400_0040);
    retire_txn(1, 1'b1, 1'b0, 1'b0, -64'sd2);
    chk("cbz_not_taken", imem_addr, 64'h100);

    // Retire held high through FETCH must not move the PC.
    retire = 1'b1;
    tick();
    chk("retire_in_fetch", imem_addr, model_pc);
    retire = 1'b0;
    fetch_txn(1, 32'h1234_5678);
    retire_txn(0, 1'b0, 1'b0, 1'b0, 64'd0);
    chk_counters();

    // PC wrap at the top of the address space.
    do_reset(64'hFFFF_FFFF_FFFF_FFFC, 1);
    fetch_txn(0, 32'h1400_0001);
    retire_txn(0, 1'b0, 1'b1, 1'b0, 64'd1);
    chk("wrap_zero", imem_addr, 64'h0);

    // Reset during FETCH with a coincident ack: ack discarded.
    reset      = 1'b1;
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_ack   = 1'b0;
    chk("rstfetch_req", {63'd0, imem_req}, 64'd0);
    chk("rstfetch_valid", {63'd0, inst_valid}, 64'd0);
    chk("rstfetch_inst", {32'd0, instruction}, 64'd0);
    chk("rstfetch_pc", currentpc, 64'hFFFF_FFFF_FFFF_FFFC);
    do_reset(64'h200, 1);

    // Reset during HOLD with retire: reset wins.
    fetch_txn(2, 32'hCAFE_F00D);
    reset         = 1'b1;
    retire        = 1'b1;
    uncond_branch = 1'b1;
    signext_imm   = 64'd100;
    startpc       = 64'h300;
    tick();
    retire        = 1'b0;
    uncond_branch = 1'b0;
    chk("rsthold_pc", currentpc, 64'h300);
    chk("rsthold_valid", {63'd0, inst_valid}, 64'd0);
    do_reset(64'h300, 1);

    // Perf-counter scenario: three retires, two waits each.
    for (int i = 0; i < 3; i++) begin
      fetch_txn(2, $urandom);
      retire_txn(1, 1'b0, 1'b0, 1'b0, 64'd0);
    end
    chk_counters();

    // Randomized transactions.
    do_reset({$urandom, $urandom_range(0, 255) * 4}, 2);
    for (int i = 0; i < 60; i++) begin
      logic [XLEN-1:0] imm;
      int sel;
      sel = $urandom_range(0, 3);
      if (sel == 0)      imm = {$urandom, $urandom};
      else if (sel == 1) imm = -64'($urandom_range(0, 64));
      else               imm = 64'($urandom_range(0, 64));
      fetch_txn($urandom_range(0, 4), $urandom);
      retire_txn($urandom_range(0, 2), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), imm);
    end
    chk_counters();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
